// File: rtl/hazard_ctl.sv
// hazard_ctl: pipeline interlock and flush control for a 5-stage in-order core.
// Latency: all outputs are combinational from the OF/EX instructions and the FSM state.
// Backpressure: it only issues stall/bubble/flush requests; a div/mod holds EX for DIV_LAT-1 stalls.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_count counters.
module hazard_ctl #(
  parameter int DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_OF,
  input  logic [31:0] instruction_EX,
  input  logic        branch_taken_EX,
  output logic        stall_IF,
  output logic        stall_OF,
  output logic        stall_EX,
  output logic        bubble_EX,
  output logic        bubble_MA,
  output logic        flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  // Opcode encodings used by the hazard checks
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;

  // FSM states
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_MC  = 1'b1;

  // A single-cycle divider needs no interlock at all
  localparam logic       MULTI_CYCLE = (DIV_LAT > 1);
  localparam logic       LAT_IS_TWO  = (DIV_LAT == 2);
  // Detect cycle is one stall; MC covers the remaining DIV_LAT-2
  localparam logic [3:0] CNT_INIT    = (DIV_LAT > 2) ? 4'(DIV_LAT - 2) : 4'd0;

  // Decoded fields
  logic [4:0] op_of;
  logic       imm_of;
  logic [3:0] rd_of;
  logic [3:0] rs1_of;
  logic [3:0] rs2_of;
  logic [4:0] op_ex;
  logic [3:0] rd_ex;

  assign op_of  = instruction_OF[31:27];
  assign imm_of = instruction_OF[26];
  assign rd_of  = instruction_OF[25:22];
  assign rs1_of = instruction_OF[21:18];
  assign rs2_of = instruction_OF[17:14];
  assign op_ex  = instruction_EX[31:27];
  assign rd_ex  = instruction_EX[25:22];

  // Immediate payload bits and unused EX source fields never influence hazards
  logic unused_fields;
  assign unused_fields = ^{instruction_OF[13:0], instruction_EX[26], instruction_EX[21:0]};

  // State registers
  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  logic reader_of;
  logic ex_is_ld;
  logic ex_is_div;
  logic load_use;
  logic mc_stall;
  logic lu_stall;
  logic flush_raw;

  // Does the OF instruction read a register (unknown opcodes count as non-readers)
  always_comb begin
    reader_of = 1'b1;
    if ($isunknown(op_of)) begin
      reader_of = 1'b0;
    end else begin
      case (op_of)
        OP_NOP, OP_BEQ, OP_BGT, OP_B, OP_CALL: reader_of = 1'b0;
        default:                               reader_of = 1'b1;
      endcase
    end
  end

  assign ex_is_ld  = (op_ex == OP_LD);
  assign ex_is_div = (op_ex == OP_DIV) || (op_ex == OP_MOD);

  // Load result is not ready until MA; any OF consumer of rd_EX must wait a cycle.
  // A store reads its rd field as the data source, so it is checked too.
  always_comb begin
    load_use = 1'b0;
    if (ex_is_ld && reader_of) begin
      load_use = (rd_ex == rs1_of) ||
                 (!imm_of && (rd_ex == rs2_of)) ||
                 ((op_of == OP_ST) && (rd_ex == rd_of));
    end
  end

  // Next-state and raw request generation; flush wins over every stall in RUN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    mc_stall  = 1'b0;
    lu_stall  = 1'b0;
    flush_raw = 1'b0;
    case (state_q)
      ST_MC: begin
        // Branch resolution is irrelevant here: EX holds the div/mod
        mc_stall = 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (branch_taken_EX) begin
          flush_raw = 1'b1;
        end else if (MULTI_CYCLE && ex_is_div && !done_q) begin
          // Detect cycle; done_q masks the same div/mod on its departure cycle
          mc_stall = 1'b1;
          if (LAT_IS_TWO) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_MC;
            cnt_d   = CNT_INIT;
          end
        end else if (load_use) begin
          lu_stall = 1'b1;
        end
      end
    endcase
  end

  // Outputs are forced low while reset is held, independent of the clock
  always_comb begin
    stall_IF  = !rst && (mc_stall || lu_stall);
    stall_OF  = !rst && (mc_stall || lu_stall);
    stall_EX  = !rst && mc_stall;
    bubble_EX = !rst && lu_stall;
    bubble_MA = !rst && mc_stall;
    flush     = !rst && flush_raw;
  end

  // FSM, countdown and departure flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Saturating event counters for front-end stalls and flushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      if (stall_IF && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 Parameter DIV_LAT, default 4, range 1..16: total cycles a div/mod instruction occupies EX; 1 means single-cycle and no interlock.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 instruction_OF  in  32  instruction in operand-fetch stage.
REQ-005 instruction_EX  in  32  instruction in execute stage.
REQ-006 branch_taken_EX  in  1  EX-stage branch/call/ret resolved taken.
REQ-007 stall_IF  out  1  hold PC and IF/OF latch.
REQ-008 stall_OF  out  1  hold OF/EX latch contents in OF.
REQ-009 stall_EX  out  1  hold EX/MA latch input; EX instruction stays in EX.
REQ-010 bubble_EX  out  1  load nop into OF/EX latch at next edge.
REQ-011 bubble_MA  out  1  load nop into EX/MA latch at next edge.
REQ-012 flush  out  1  nop both IF/OF and OF/EX latches at next edge.

Function
REQ-013 Field decode SHALL be: opcode [31:27], imm [26], rd [25:22], rs1 [21:18], rs2 [17:14]; ld=01110, st=01111, div=00011, mod=00100, nop=01101.
REQ-014 Reader of OF SHALL mean opcode not in {nop, beq 10000, bgt 10001, b 10010, call 10011}; X opcode is treated as non-reader.
REQ-015 Load-use hazard SHALL be: EX opcode ld AND OF reader AND (rd_EX==rs1_OF OR (imm_OF==0 AND rd_EX==rs2_OF) OR (OF opcode st AND rd_EX==rd_OF)).
REQ-016 Load-use: in the same cycle, combinationally, stall_IF=stall_OF=bubble_EX=1; one stall cycle per occurrence; state unchanged.
REQ-017 FSM states SHALL be RUN and MC; 4-bit down-counter cnt; 1-bit flag done_q.
REQ-018 In RUN, with DIV_LAT>1, EX opcode div/mod and done_q=0: stall_IF=stall_OF=stall_EX=bubble_MA=1 this cycle (detect cycle).
REQ-019 Detect-cycle transition: DIV_LAT==2 -> stay RUN, set done_q; DIV_LAT>2 -> go MC, cnt<=DIV_LAT-2.
REQ-020 In MC: stall_IF=stall_OF=stall_EX=bubble_MA=1 every cycle; if cnt==1 -> RUN and set done_q, else cnt<=cnt-1.
REQ-021 Total stall cycles per div/mod SHALL equal DIV_LAT-1; the instruction leaves EX on the edge after the last stall cycle.
REQ-022 done_q SHALL clear on the edge after the cycle in which it was 1, suppressing re-detection of the departing div/mod only.
REQ-023 In RUN, branch_taken_EX=1: flush=1 that cycle; flush SHALL override load-use and detect outputs (all other outputs 0).
REQ-024 In MC, branch_taken_EX SHALL be ignored (flush=0).
REQ-025 All outputs not asserted by REQ-016..REQ-023 SHALL be 0.

Reset
REQ-026 While rst=1: state=RUN, cnt=0, done_q=0, all outputs 0 regardless of instruction inputs; perf counters 0.
REQ-027 Reset asserted mid-MC SHALL abort the sequence immediately; after release a div/mod still in EX restarts a full DIV_LAT-1 stall.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: add outputs stall_cycles (out, 32, count of cycles with stall_IF=1) and flush_count (out, 16, count of flush cycles), both saturating at all-ones, reset to 0.
REQ-029 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 EX=ld r3, OF=add r5,r3,r2 -> one cycle stall_IF=stall_OF=bubble_EX=1, then all 0.
REQ-031 EX=ld r3, OF=st r3,[r1] (rd=r3, imm=1) -> load-use stall 1 cycle; OF=add r5,r1,#3 with rs2 field=3 (imm=1) -> no stall.
REQ-032 DIV_LAT=4, EX=div held 3 cycles -> stall_EX=bubble_MA=1 for exactly 3 cycles, 0 on 4th with div still in EX.
REQ-033 branch_taken_EX=1 with EX=b, OF=ld -> flush=1, stall outputs 0; same with FSM in MC -> flush=0.
REQ-034 rst pulsed in 2nd MC cycle -> outputs 0 async; after release with div in EX, 3 new stall cycles.
REQ-035 With HAZARD_PERF_CNT_EN, sequence REQ-030 then REQ-032 then one flush -> stall_cycles=4, flush_count=1.
